// File: rtl/mod_blkreg_deser.sv
// Block deserializer: collects N elements of W bits into one registered N*W-bit block
// with a valid/ready handshake on both sides and a one-block hold stage under backpressure.
module mod_blkreg_deser #(
  parameter int W     = 8,
  parameter int N     = 16,
  parameter int ORDER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_data,
  output logic [$clog2(N+1)-1:0] count
);

  localparam int CW = $clog2(N+1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N*W-1:0]  buf_q, buf_d;
  logic            out_valid_q, out_valid_d;
  logic [N*W-1:0]  out_data_q, out_data_d;

  logic            accept_s;
  logic            drain_s;
  logic            slot_free_s;
  logic            load_s;
  logic [N*W-1:0]  load_blk_s;

  // Logical element position to physical slot in the block.
  function automatic int phys_slot(input int k);
    return (ORDER == 1) ? (N - 1 - k) : k;
  endfunction

  assign in_ready  = reset || (state_q == FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    load_s      = 1'b0;
    load_blk_s  = buf_q;

    accept_s    = in_valid && in_ready;
    drain_s     = out_valid_q && out_ready;
    slot_free_s = !out_valid_q || out_ready;

    // clear beats accept and never touches the output register
    if (clear) begin
      count_d = '0;
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_s) begin
            buf_d[phys_slot(int'(count_q))*W +: W] = in_data;
            if (count_q == CW'(N - 1)) begin
              if (slot_free_s) begin
                load_s     = 1'b1;
                load_blk_s = buf_d;
                count_d    = '0;
              end else begin
                count_d = CW'(N);
                state_d = HOLD;
              end
            end else begin
              count_d = count_q + CW'(1);
            end
          end else begin
            count_d = count_q;
          end
        end
        HOLD: begin
          if (slot_free_s) begin
            load_s     = 1'b1;
            load_blk_s = buf_q;
            count_d    = '0;
            state_d    = FILL;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
        end
      endcase
    end

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = load_blk_s;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mod_blkreg_deser.sv
// Directed bench for mod_blkreg_deser (N=16, W=8); ORDER=0 and ORDER=1 instances share stimulus.
module tb_mod_blkreg_deser;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         clear;
  logic         out_ready;
  logic         in_ready0, in_ready1;
  logic         out_valid0, out_valid1;
  logic [127:0] out_data0, out_data1;
  logic [4:0]   count0, count1;

  int errors = 0;
  int checks = 0;

  mod_blkreg_deser #(.W(8), .N(16), .ORDER(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .clear(clear), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .count(count0)
  );

  mod_blkreg_deser #(.W(8), .N(16), .ORDER(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .clear(clear), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block of elements base, base+1, ... in logical order; rev selects the ORDER=1 layout.
  function automatic logic [127:0] mk(input logic [7:0] base, input bit rev);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      if (rev) b[(15-k)*8 +: 8] = base + 8'(k);
      else     b[k*8 +: 8]      = base + 8'(k);
    end
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; clear = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready0); end
    step(); step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count0); end
    checks++; if (out_data0 !== 128'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data0); end
    reset = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_no_accept got=%0d exp=0", count0); end
  endtask

  task automatic test_order();
    out_ready = 1'b1;
    feed(8'h00, 15);
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL order_early_valid got=%b exp=0", out_valid0); end
    checks++; if (count0 !== 5'd15) begin errors++; $display("FAIL order_count15 got=%0d exp=15", count0); end
    feed(8'h0F, 1);
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL order_valid got=%b exp=1", out_valid0); end
    checks++; if (out_data0[7:0] !== 8'h00 || out_data0[127:120] !== 8'h0F) begin errors++; $display("FAIL order0_ends got=%h exp lo=00 hi=0F", out_data0); end
    checks++; if (out_data0 !== mk(8'h00, 1'b0)) begin errors++; $display("FAIL order0_block got=%h exp=%h", out_data0, mk(8'h00, 1'b0)); end
    checks++; if (out_data1[127:120] !== 8'h00 || out_data1[7:0] !== 8'h0F) begin errors++; $display("FAIL order1_ends got=%h exp hi=00 lo=0F", out_data1); end
    checks++; if (out_data1 !== mk(8'h00, 1'b1)) begin errors++; $display("FAIL order1_block got=%h exp=%h", out_data1, mk(8'h00, 1'b1)); end
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL order_count_wrap got=%0d exp=0", count0); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL order_single_pulse got=%b exp=0", out_valid0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    feed(8'h20, 16);
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== mk(8'h20, 1'b0)) begin errors++; $display("FAIL bp_block1 got=%b/%h exp=1/%h", out_valid0, out_data0, mk(8'h20, 1'b0)); end
    feed(8'h40, 16);
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL bp_hold_count got=%0d exp=16", count0); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got=%b exp=0", in_ready0); end
    in_valid = 1'b1; in_data = 8'hEE;
    step(); step();
    checks++; if (out_data0 !== mk(8'h20, 1'b0) || out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b/%h exp=1/%h", out_valid0, out_data0, mk(8'h20, 1'b0)); end
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL bp_hold_keep got=%0d exp=16", count0); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== mk(8'h40, 1'b0)) begin errors++; $display("FAIL bp_block2 got=%b/%h exp=1/%h", out_valid0, out_data0, mk(8'h40, 1'b0)); end
    checks++; if (in_ready0 !== 1'b1 || count0 !== 5'd0) begin errors++; $display("FAIL bp_release got=%b/%0d exp=1/0", in_ready0, count0); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid0); end
  endtask

  task automatic test_hold_clear();
    out_ready = 1'b0;
    feed(8'h80, 32);
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL hc_hold got=%0d exp=16", count0); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (count0 !== 5'd0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL hc_clear got=%0d/%b exp=0/1", count0, in_ready0); end
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== mk(8'h80, 1'b0)) begin errors++; $display("FAIL hc_out_kept got=%b/%h exp=1/%h", out_valid0, out_data0, mk(8'h80, 1'b0)); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL hc_no_load got=%b exp=0", out_valid0); end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    feed(8'hA0, 5);
    checks++; if (count0 !== 5'd5) begin errors++; $display("FAIL clr_count5 got=%0d exp=5", count0); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL clr_count0 got=%0d exp=0", count0); end
    feed(8'h60, 16);
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== mk(8'h60, 1'b0)) begin errors++; $display("FAIL clr_clean got=%b/%h exp=1/%h", out_valid0, out_data0, mk(8'h60, 1'b0)); end
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready0); end
      step();
      if (out_valid0 === 1'b1) pulses++;
      checks++; if (out_valid0 !== ((i % 16) == 15)) begin errors++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, out_valid0, ((i % 16) == 15)); end
      if ((i % 16) == 15) begin
        checks++; if (out_data0 !== mk(8'(i - 15), 1'b0)) begin errors++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, out_data0, mk(8'(i - 15), 1'b0)); end
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    out_ready = 1'b1;
    feed(8'h10, 9);
    checks++; if (count0 !== 5'd9) begin errors++; $display("FAIL rm_count9 got=%0d exp=9", count0); end
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (count0 !== 5'd0 || out_valid0 !== 1'b0 || out_data0 !== 128'd0) begin errors++; $display("FAIL rm_reset1 got=%0d/%b/%h exp=0/0/0", count0, out_valid0, out_data0); end
    out_ready = 1'b0;
    feed(8'hC0, 32);
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL rm_hold got=%0d exp=16", count0); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rm_reset_ready got=%b exp=1", in_ready0); end
    step();
    reset = 1'b0;
    checks++; if (count0 !== 5'd0 || out_valid0 !== 1'b0 || out_data0 !== 128'd0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL rm_reset2 got=%0d/%b/%h/%b exp=0/0/0/1", count0, out_valid0, out_data0, in_ready0); end
    out_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16);
      in_data  = 8'hD0 + 8'(i);
      step();
      if (out_valid0 === 1'b1) begin
        pulses++;
        checks++; if (out_data0 !== mk(8'hD0, 1'b0)) begin errors++; $display("FAIL rm_data got=%h exp=%h", out_data0, mk(8'hD0, 1'b0)); end
      end
    end
    in_valid = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL rm_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_hold_clear();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_blkreg_deser.md
MOD_BLKREG_DESER -- requirements
Module: mod_blkreg_deser

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the element width in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 16, meaning the number of elements per block (N >= 2).
REQ-003 The block SHALL have parameter ORDER, default 0: 0 = first element at index 0; 1 = first element at index N-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid element.
REQ-007 The block SHALL have port in_data, input, W bits: the element.
REQ-008 The block SHALL have port in_ready, output, 1 bit: an element is accepted this cycle when in_valid is also high.
REQ-009 The block SHALL have port clear, input, 1 bit: discard the partially or fully assembled block that has not yet transferred.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a complete block.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle when out_valid is also high.
REQ-012 The block SHALL have port out_data, output, N*W bits: the assembled block, registered.
REQ-013 The block SHALL have port count, output, clog2(N+1) bits: the number of elements held in the fill stage.

Function
REQ-014 Accept = in_valid && in_ready; drain = out_valid && out_ready; slot_free = !out_valid || out_ready.
REQ-015 Fill-stage FSM SHALL have two states: FILL (in_ready=1) and HOLD (in_ready=0, count=N).
REQ-016 In FILL, an accept with count<N-1 SHALL store the element at logical position count and increment count.
REQ-017 With ORDER=0, logical position k SHALL map to out_data[k*W +: W]; with ORDER=1, it SHALL map to out_data[(N-1-k)*W +: W].
REQ-018 In FILL, an accept with count=N-1 and slot_free SHALL load the full block, including this element, into out_data, set out_valid, set count=0, and stay in FILL.
REQ-019 In FILL, an accept with count=N-1 and !slot_free SHALL store the element, set count=N, and enter HOLD.
REQ-020 In HOLD with slot_free, the block SHALL load the held block into out_data, set out_valid, set count=0, and enter FILL.
REQ-021 In HOLD with !slot_free, the block SHALL keep all state unchanged.
REQ-022 A drain with no load in the same cycle SHALL clear out_valid; a drain with a load SHALL keep out_valid=1 with the new block (back-to-back).
REQ-023 out_data SHALL change only on a load; while out_valid=1 and out_ready=0, out_data SHALL be stable.
REQ-024 Latency: out_valid SHALL rise on the edge that accepts element N-1 when slot_free; the block is visible the cycle after that accept.
REQ-025 With out_ready held at 1 and in_valid held at 1, the block SHALL sustain one element per cycle and one block per N cycles with no bubbles.
REQ-026 clear SHALL set count=0 and state=FILL, and SHALL discard any element offered in the same cycle (clear beats accept).
REQ-027 clear in HOLD SHALL discard the held block with no load; out_valid/out_data SHALL be unaffected by clear, and a drain in the same cycle still applies.
REQ-028 count wrap: count SHALL never exceed N; after a load it SHALL restart at 0.
REQ-029 Element storage not yet overwritten after a load SHALL be don't-care; only positions written since the last load contribute to the next block.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL set state=FILL, count=0, out_valid=0, out_data=0 and all fill storage=0.
REQ-031 During reset the block SHALL hold in_ready=1, ignore in_valid/clear/out_ready, and accept no element.
REQ-032 Reset mid-block or in HOLD SHALL discard all partial and held data, and no out_valid SHALL follow.

Verification
REQ-033 N=16, W=8, ORDER=0, out_ready=1: feed 0x00..0x0F on 16 consecutive cycles -> out_valid is 1 for one cycle and out_data[7:0]=0x00, out_data[127:120]=0x0F.
REQ-034 Same stream with ORDER=1 -> out_data[127:120]=0x00 and out_data[7:0]=0x0F.
REQ-035 Backpressure: out_ready=0, two blocks offered -> block 1 stays on out_data, the FSM enters HOLD with count=16 and in_ready=0; raise out_ready -> block 2 loads the next cycle, then in_ready=1 and count=0.
REQ-036 Clear: accept 5 elements, assert clear with in_valid=1 -> count=0 and the element is dropped; the next 16 elements form a clean block.
REQ-037 Continuous stream of 4 blocks with out_ready=1 -> out_valid pulses every 16 cycles and in_ready never drops.
REQ-038 Reset asserted at count=9 and again in HOLD -> all outputs return to reset values, and the next 16 accepts produce exactly one block.
